// File: rtl/uart_rx_if.sv
// Signal bundle between the serial pin/consumer side and the UART receiver.
// The master drives the line and the acknowledge; the slave (receiver) returns byte and status.
interface uart_rx_if;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  modport master (output RX, clr_rdy, input rx_data, rdy, frm_err);
  modport slave  (input RX, clr_rdy, output rx_data, rdy, frm_err);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, sticky ready flag
// and a one-cycle framing-error pulse when the stop bit samples low.
module uart_rx #(
    parameter int unsigned BAUD_CYCLES = 2604
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);

    localparam int unsigned HALF_CYCLES = BAUD_CYCLES / 2;
    localparam int unsigned CntW        = $clog2(BAUD_CYCLES);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic              rx_ff1_q, rx_sync_q;
    logic [CntW-1:0]   baud_cnt_q, baud_cnt_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rdy_q, rdy_d;
    logic              frm_err_q, frm_err_d;
    logic              strobe;

    assign strobe = (baud_cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rx_ff1_q   <= 1'b1;
            rx_sync_q  <= 1'b1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rdy_q      <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_ff1_q   <= bus.RX;
            rx_sync_q  <= rx_ff1_q;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rdy_q      <= rdy_d;
            frm_err_q  <= frm_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rdy_d      = rdy_q;
        frm_err_d  = 1'b0;

        // Clear is applied first so that a set later in this block wins a collision.
        if (bus.clr_rdy) rdy_d = 1'b0;

        if (state_q != StIdle) begin
            baud_cnt_d = strobe ? CntW'(BAUD_CYCLES - 1) : baud_cnt_q - 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (!rx_sync_q) begin
                    state_d    = StStart;
                    baud_cnt_d = CntW'(HALF_CYCLES - 1);
                    bit_cnt_d  = '0;
                    rdy_d      = 1'b0;
                end
            end
            StStart: begin
                if (strobe) state_d = rx_sync_q ? StIdle : StData;
            end
            StData: begin
                if (strobe) begin
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 4'd7) state_d = StStop;
                end
            end
            StStop: begin
                // Leave mid-stop-bit so a back-to-back start edge is not missed.
                if (strobe) begin
                    state_d = StIdle;
                    if (rx_sync_q) begin
                        rx_data_d = shift_q;
                        rdy_d     = 1'b1;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.rx_data = rx_data_q;
    assign bus.rdy     = rdy_q;
    assign bus.frm_err = frm_err_q;

endmodule
